// File: rtl/pc_flow_pkg.sv
// Shared types for the RAT program-flow sequencer: decoded flow classes,
// sequencer states and the default interrupt vector.
package pc_flow_pkg;

   typedef enum logic [2:0] {
      SEQ  = 3'd0,
      BRN  = 3'd1,
      BREQ = 3'd2,
      BRNE = 3'd3,
      BRCS = 3'd4,
      BRCC = 3'd5,
      CALL = 3'd6,
      RET  = 3'd7
   } flow_op_t;

   typedef enum logic [1:0] {
      INIT  = 2'd0,
      FETCH = 2'd1,
      EXEC  = 2'd2,
      INTR  = 2'd3
   } state_t;

   localparam logic [9:0] DEF_INTR_VEC = 10'h3FF;

endpackage

// File: rtl/pc_flow_ctrl_if.sv
// Decoder/PC-side bundle of the flow sequencer. The master is the decoder and
// program counter; the slave is the sequencer itself.
interface pc_flow_ctrl_if #(
   parameter int ADDR_W = 10
);
   logic [2:0]        FLOW_OP;
   logic              RETI_EN;
   logic [ADDR_W-1:0] IMM_ADDR;
   logic              Z_FLAG;
   logic              C_FLAG;
   logic              IE_SET;
   logic              IE_CLR;
   logic              INTR;
   logic [ADDR_W-1:0] PC_COUNT;
   logic              PC_LD;
   logic              PC_INC;
   logic [ADDR_W-1:0] PC_DIN;
   logic              FETCH;
   logic              INTR_ACK;
   logic              IE_FLAG;
   logic              STACK_OVF;
   logic              STACK_UNF;

   modport master (
      output FLOW_OP, RETI_EN, IMM_ADDR, Z_FLAG, C_FLAG, IE_SET, IE_CLR, INTR, PC_COUNT,
      input  PC_LD, PC_INC, PC_DIN, FETCH, INTR_ACK, IE_FLAG, STACK_OVF, STACK_UNF
   );

   modport slave (
      input  FLOW_OP, RETI_EN, IMM_ADDR, Z_FLAG, C_FLAG, IE_SET, IE_CLR, INTR, PC_COUNT,
      output PC_LD, PC_INC, PC_DIN, FETCH, INTR_ACK, IE_FLAG, STACK_OVF, STACK_UNF
   );

endinterface

// File: rtl/ret_stack.sv
// Return-address LIFO. Top of stack is read combinationally so a pop can use
// its data in the same cycle; push while full and pop while empty are ignored.
module ret_stack #(
   parameter int W     = 10,
   parameter int DEPTH = 8
) (
   input  logic         clk,
   input  logic         srst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] ptr_reg;
   logic [AW-1:0] top_idx;

   assign full    = (ptr_reg == PW'(DEPTH));
   assign empty   = (ptr_reg == '0);
   // ptr counts entries, so the top lives one below it (wraps harmlessly when empty)
   assign top_idx = ptr_reg[AW-1:0] - AW'(1);
   assign dout    = mem[top_idx];

   always_ff @(posedge clk) begin
      if (push && !full) begin
         mem[ptr_reg[AW-1:0]] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         ptr_reg <= '0;
      end else if (push && !full) begin
         ptr_reg <= ptr_reg + PW'(1);
      end else if (pop && !empty) begin
         ptr_reg <= ptr_reg - PW'(1);
      end
   end

endmodule

// File: rtl/pc_flow_ctrl.sv
// RAT program-flow sequencer: fetch/execute FSM, branch resolution, CALL/RET
// via the return stack, interrupt vectoring and the interrupt-enable flag.
module pc_flow_ctrl
   import pc_flow_pkg::*;
#(
   parameter int                ADDR_W      = 10,
   parameter int                STACK_DEPTH = 8,
   parameter logic [ADDR_W-1:0] INTR_VEC    = ADDR_W'(DEF_INTR_VEC)
) (
   input  logic          CLK,
   input  logic          RST,
   pc_flow_ctrl_if.slave bus
);
   state_t            state_reg;
   flow_op_t          op;
   logic              ie_reg, ovf_reg, unf_reg;
   logic              taken;
   logic              pc_ld, pc_inc, fetch_en, intr_ack;
   logic [ADDR_W-1:0] pc_din;
   logic              push_req, pop_req, unf_evt;
   logic              stk_full, stk_empty;
   logic [ADDR_W-1:0] stk_dout;

   assign op = flow_op_t'(bus.FLOW_OP);

   ret_stack #(
      .W     (ADDR_W),
      .DEPTH (STACK_DEPTH)
   ) u_stack (
      .clk   (CLK),
      .srst  (RST),
      .push  (push_req),
      .pop   (pop_req),
      .din   (bus.PC_COUNT),
      .dout  (stk_dout),
      .full  (stk_full),
      .empty (stk_empty)
   );

   always_comb begin
      taken = 1'b0;
      case (op)
         BRN:     taken = 1'b1;
         BREQ:    taken = bus.Z_FLAG;
         BRNE:    taken = !bus.Z_FLAG;
         BRCS:    taken = bus.C_FLAG;
         BRCC:    taken = !bus.C_FLAG;
         default: taken = 1'b0;
      endcase
   end

   always_comb begin
      pc_ld    = 1'b0;
      pc_inc   = 1'b0;
      pc_din   = '0;
      fetch_en = 1'b0;
      intr_ack = 1'b0;
      push_req = 1'b0;
      pop_req  = 1'b0;
      unf_evt  = 1'b0;
      case (state_reg)
         FETCH: begin
            fetch_en = 1'b1;
            pc_inc   = 1'b1;
         end
         EXEC: begin
            if (op == CALL) begin
               push_req = 1'b1;
               pc_ld    = 1'b1;
               pc_din   = bus.IMM_ADDR;
            end else if (op == RET) begin
               // An empty stack turns RET into a sequential no-op
               if (stk_empty) begin
                  unf_evt = 1'b1;
               end else begin
                  pop_req = 1'b1;
                  pc_ld   = 1'b1;
                  pc_din  = stk_dout;
               end
            end else if (taken) begin
               pc_ld  = 1'b1;
               pc_din = bus.IMM_ADDR;
            end
         end
         INTR: begin
            push_req = 1'b1;
            pc_ld    = 1'b1;
            pc_din   = INTR_VEC;
            intr_ack = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg <= INIT;
         ie_reg    <= 1'b0;
         ovf_reg   <= 1'b0;
         unf_reg   <= 1'b0;
      end else begin
         if (push_req && stk_full) ovf_reg <= 1'b1;
         if (unf_evt)              unf_reg <= 1'b1;
         case (state_reg)
            INIT:  state_reg <= FETCH;
            FETCH: state_reg <= EXEC;
            EXEC: begin
               // Later assignments win: RETI, then SEI, then CLI
               if (op == RET && bus.RETI_EN) ie_reg <= 1'b1;
               if (bus.IE_SET)               ie_reg <= 1'b1;
               if (bus.IE_CLR)               ie_reg <= 1'b0;
               state_reg <= (bus.INTR && ie_reg) ? INTR : FETCH;
            end
            INTR: begin
               ie_reg    <= 1'b0;
               state_reg <= FETCH;
            end
            default: state_reg <= INIT;
         endcase
      end
   end

   assign bus.PC_LD     = pc_ld;
   assign bus.PC_INC    = pc_inc;
   assign bus.PC_DIN    = pc_din;
   assign bus.FETCH     = fetch_en;
   assign bus.INTR_ACK  = intr_ack;
   assign bus.IE_FLAG   = ie_reg;
   assign bus.STACK_OVF = ovf_reg;
   assign bus.STACK_UNF = unf_reg;

endmodule

// File: tb/tb_pc_flow_ctrl.sv
// Directed scoreboard bench for pc_flow_ctrl: each driven cycle queues its
// hand-computed outputs, and a negedge monitor pops and compares them.
module tb_pc_flow_ctrl;
   import pc_flow_pkg::*;

   logic CLK = 1'b0;
   logic RST;
   always #5 CLK = ~CLK;

   pc_flow_ctrl_if #(.ADDR_W(10)) bus ();

   pc_flow_ctrl #(
      .ADDR_W      (10),
      .STACK_DEPTH (8),
      .INTR_VEC    (10'h3FF)
   ) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   typedef struct packed {
      logic       ld;
      logic       inc;
      logic [9:0] din;
      logic       fetch;
      logic       ack;
      logic       ie;
      logic       ovf;
      logic       unf;
   } obs_t;

   obs_t  exp_q [$];
   string tag_q [$];
   int    vectors     = 0;
   int    miscompares = 0;
   logic  e_ie  = 1'b0;
   logic  e_ovf = 1'b0;
   logic  e_unf = 1'b0;

   obs_t  mon_exp, mon_act;
   string mon_tag;

   always @(negedge CLK) begin
      if (exp_q.size() > 0) begin
         mon_exp = exp_q.pop_front();
         mon_tag = tag_q.pop_front();
         mon_act.ld    = bus.PC_LD;
         mon_act.inc   = bus.PC_INC;
         mon_act.din   = bus.PC_DIN;
         mon_act.fetch = bus.FETCH;
         mon_act.ack   = bus.INTR_ACK;
         mon_act.ie    = bus.IE_FLAG;
         mon_act.ovf   = bus.STACK_OVF;
         mon_act.unf   = bus.STACK_UNF;
         vectors++;
         if (mon_act !== mon_exp) begin
            miscompares++;
            $display("FAIL %s: got ld=%b inc=%b din=%h fetch=%b ack=%b ie=%b ovf=%b unf=%b, want ld=%b inc=%b din=%h fetch=%b ack=%b ie=%b ovf=%b unf=%b",
                     mon_tag, mon_act.ld, mon_act.inc, mon_act.din, mon_act.fetch, mon_act.ack,
                     mon_act.ie, mon_act.ovf, mon_act.unf, mon_exp.ld, mon_exp.inc, mon_exp.din,
                     mon_exp.fetch, mon_exp.ack, mon_exp.ie, mon_exp.ovf, mon_exp.unf);
         end
      end
   end

   // One clock of stimulus plus the outputs expected during that clock
   task automatic cyc(input string name, input logic rst, input flow_op_t op,
                      input logic [9:0] imm, input logic z, input logic c,
                      input logic set, input logic clr, input logic reti, input logic intr,
                      input logic [9:0] pc, input logic ld, input logic inc,
                      input logic [9:0] din, input logic fetch, input logic ack);
      obs_t e;
      RST          = rst;
      bus.FLOW_OP  = op;
      bus.IMM_ADDR = imm;
      bus.Z_FLAG   = z;
      bus.C_FLAG   = c;
      bus.IE_SET   = set;
      bus.IE_CLR   = clr;
      bus.RETI_EN  = reti;
      bus.INTR     = intr;
      bus.PC_COUNT = pc;
      e.ld = ld; e.inc = inc; e.din = din; e.fetch = fetch; e.ack = ack;
      e.ie = e_ie; e.ovf = e_ovf; e.unf = e_unf;
      exp_q.push_back(e);
      tag_q.push_back(name);
      @(posedge CLK);
      #1;
   endtask

   // FETCH cycle followed by an EXEC cycle
   task automatic instr(input string name, input flow_op_t op, input logic [9:0] imm,
                        input logic z, input logic c, input logic set, input logic clr,
                        input logic reti, input logic intr, input logic [9:0] pc,
                        input logic ld, input logic [9:0] din);
      cyc({name, "/fetch"}, 1'b0, SEQ, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, intr, pc,
          1'b0, 1'b1, 10'h000, 1'b1, 1'b0);
      cyc({name, "/exec"}, 1'b0, op, imm, z, c, set, clr, reti, intr, pc,
          ld, 1'b0, din, 1'b0, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      RST = 1'b1;
      bus.FLOW_OP = '0; bus.IMM_ADDR = '0; bus.Z_FLAG = 1'b0; bus.C_FLAG = 1'b0;
      bus.IE_SET = 1'b0; bus.IE_CLR = 1'b0; bus.RETI_EN = 1'b0; bus.INTR = 1'b0;
      bus.PC_COUNT = '0;
      repeat (2) @(posedge CLK);
      #1;

      // Reset state and plain sequential flow
      cyc("init", 1'b0, SEQ, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000,
          1'b0, 1'b0, 10'h000, 1'b0, 1'b0);
      instr("seq0", SEQ, 10'h155, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h001, 1'b0, 10'h000);
      instr("seq1", SEQ, 10'h2AA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h002, 1'b0, 10'h000);

      // Conditional branch truth tables; the unused flag is set opposite
      instr("breq_z1", BREQ, 10'h0A5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h003, 1'b1, 10'h0A5);
      instr("breq_z0", BREQ, 10'h0A5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h0A6, 1'b0, 10'h000);
      instr("brne_z0", BRNE, 10'h0B7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h0A7, 1'b1, 10'h0B7);
      instr("brne_z1", BRNE, 10'h0B7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h0B8, 1'b0, 10'h000);
      instr("brcs_c1", BRCS, 10'h1C3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h0B9, 1'b1, 10'h1C3);
      instr("brcs_c0", BRCS, 10'h1C3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h1C4, 1'b0, 10'h000);
      instr("brcc_c0", BRCC, 10'h2D4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h1C5, 1'b1, 10'h2D4);
      instr("brcc_c1", BRCC, 10'h2D4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h2D5, 1'b0, 10'h000);
      instr("brn",     BRN,  10'h3FE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h2D6, 1'b1, 10'h3FE);

      // CALL/RET and nested LIFO order
      instr("call",  CALL, 10'h100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h011, 1'b1, 10'h100);
      instr("body",  SEQ,  10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h101, 1'b0, 10'h000);
      instr("ret",   RET,  10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h102, 1'b1, 10'h011);
      instr("callA", CALL, 10'h110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h021, 1'b1, 10'h110);
      instr("callB", CALL, 10'h120, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h031, 1'b1, 10'h120);
      instr("callC", CALL, 10'h130, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h041, 1'b1, 10'h130);
      instr("retC",  RET,  10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h131, 1'b1, 10'h041);
      instr("retB",  RET,  10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h042, 1'b1, 10'h031);
      instr("retA",  RET,  10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h032, 1'b1, 10'h021);

      // Overflow: 9 calls into an 8-deep stack, then 9 returns
      for (int i = 0; i < 9; i++) begin
         instr("call_fill", CALL, 10'(10'h300 + i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
               10'(10'h200 + i), 1'b1, 10'(10'h300 + i));
      end
      e_ovf = 1'b1;
      for (int i = 0; i < 8; i++) begin
         instr("ret_drain", RET, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h3A0,
               1'b1, 10'(10'h207 - i));
      end
      instr("ret_empty", RET, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h3A0, 1'b0, 10'h000);
      e_unf = 1'b1;

      // Interrupt entry and RETI
      instr("sei", SEQ, 10'h000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 10'h01F, 1'b0, 10'h000);
      e_ie = 1'b1;
      instr("intr_trig", SEQ, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'h020, 1'b0, 10'h000);
      cyc("intr_vec", 1'b0, SEQ, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'h020,
          1'b1, 1'b0, 10'h3FF, 1'b0, 1'b1);
      e_ie = 1'b0;
      instr("reti", RET, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'h000, 1'b1, 10'h020);
      e_ie = 1'b1;

      // SEI+CLI together clears
      instr("sei_cli", SEQ, 10'h000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'h021, 1'b0, 10'h000);
      e_ie = 1'b0;
      instr("sei2", SEQ, 10'h000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'h022, 1'b0, 10'h000);
      e_ie = 1'b1;

      // Reset arriving during the INTR state
      instr("intr2_trig", SEQ, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'h050, 1'b0, 10'h000);
      cyc("intr_rst", 1'b1, SEQ, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'h050,
          1'b1, 1'b0, 10'h3FF, 1'b0, 1'b1);
      e_ie = 1'b0; e_ovf = 1'b0; e_unf = 1'b0;
      cyc("init_after_rst", 1'b0, SEQ, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'h050,
          1'b0, 1'b0, 10'h000, 1'b0, 1'b0);
      instr("ret_after_rst", RET, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 10'h000);
      e_unf = 1'b1;
      instr("call_after_rst", CALL, 10'h123, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h061, 1'b1, 10'h123);
      instr("ret_after_call", RET, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h124, 1'b1, 10'h061);
      instr("tail", SEQ, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h062, 1'b0, 10'h000);

      @(negedge CLK);
      @(negedge CLK);
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
